// File: rtl/wb_arbiter2.sv
// wb_arbiter2 - two-master / one-slave classic Wishbone arbiter.
// Master 0 is the midgetv core, master 1 a loader/DMA/debug master.
// The grant is registered and held for the whole CYC burst of the owner.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to add a stall counter with
// per-master ERR pulses and a sticky tmo_flag output.
module wb_arbiter2 #(
   parameter int ADRWIDTH               = 32,
   parameter int PRIORITY_MODE          = 0,
   parameter int DAT_ZERO_WHEN_INACTIVE = 1,
   parameter int TIMEOUT_CYCLES         = 255
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   input  logic                m0_CYC_I,
   input  logic                m0_STB_I,
   input  logic                m0_WE_I,
   input  logic [3:0]          m0_SEL_I,
   input  logic [ADRWIDTH-1:0] m0_ADR_I,
   input  logic [31:0]         m0_DAT_I,
   output logic [31:0]         m0_DAT_O,
   output logic                m0_ACK_O,
   input  logic                m1_CYC_I,
   input  logic                m1_STB_I,
   input  logic                m1_WE_I,
   input  logic [3:0]          m1_SEL_I,
   input  logic [ADRWIDTH-1:0] m1_ADR_I,
   input  logic [31:0]         m1_DAT_I,
   output logic [31:0]         m1_DAT_O,
   output logic                m1_ACK_O,
   output logic                CYC_O,
   output logic                STB_O,
   output logic                WE_O,
   output logic [3:0]          SEL_O,
   output logic [ADRWIDTH-1:0] ADR_O,
   output logic [31:0]         DAT_O,
   input  logic [31:0]         DAT_I,
   input  logic                ACK_I,
   output logic [1:0]          gnt
`ifdef WB_ARB_TIMEOUT_EN
   ,
   output logic                m0_ERR_O,
   output logic                m1_ERR_O,
   output logic                tmo_flag
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G0   = 2'd1,
      ST_G1   = 2'd2
   } state_t;

   // Last counter value before the watchdog fires (counter counts completed stall cycles).
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t r_state;
   state_t w_state_next;
   logic   r_last_gnt;     // 0 = m0 was granted last, 1 = m1
   logic   w_g0;
   logic   w_g1;
   logic   w_stb_mux;      // granted master's strobe before watchdog masking
   logic   w_tmo_hit;

   // Outputs are all forced quiet while reset is held, so an ACK in the reset cycle is dropped.
   assign w_g0 = RST_I && (r_state == ST_G0);
   assign w_g1 = RST_I && (r_state == ST_G1);
   assign gnt  = {w_g1, w_g0};

   // State and round-robin history register; last_gnt is updated on every entry into a grant.
   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_state_next == ST_G0 && r_state != ST_G0) begin
            r_last_gnt <= 1'b0;
         end else if (w_state_next == ST_G1 && r_state != ST_G1) begin
            r_last_gnt <= 1'b1;
         end
      end
   end

   // Next-state: hold the grant while the owner keeps CYC, hand over directly when it drops.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (m0_CYC_I && m1_CYC_I) begin
               if (PRIORITY_MODE == 0) begin
                  w_state_next = ST_G0;
               end else begin
                  w_state_next = r_last_gnt ? ST_G0 : ST_G1;
               end
            end else if (m0_CYC_I) begin
               w_state_next = ST_G0;
            end else if (m1_CYC_I) begin
               w_state_next = ST_G1;
            end
         end
         ST_G0: begin
            if (!m0_CYC_I) begin
               w_state_next = m1_CYC_I ? ST_G1 : ST_IDLE;
            end
         end
         ST_G1: begin
            if (!m1_CYC_I) begin
               w_state_next = m0_CYC_I ? ST_G0 : ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Slave-side mux: the granted master drives the slave; idle drives all zeros.
   always_comb begin
      CYC_O     = 1'b0;
      w_stb_mux = 1'b0;
      WE_O      = 1'b0;
      SEL_O     = '0;
      ADR_O     = '0;
      DAT_O     = '0;
      if (w_g0) begin
         CYC_O     = m0_CYC_I;
         w_stb_mux = m0_STB_I;
         WE_O      = m0_WE_I;
         SEL_O     = m0_SEL_I;
         ADR_O     = m0_ADR_I;
         DAT_O     = m0_DAT_I;
      end else if (w_g1) begin
         CYC_O     = m1_CYC_I;
         w_stb_mux = m1_STB_I;
         WE_O      = m1_WE_I;
         SEL_O     = m1_SEL_I;
         ADR_O     = m1_ADR_I;
         DAT_O     = m1_DAT_I;
      end
   end

   assign STB_O    = w_stb_mux && !w_tmo_hit;
   assign m0_ACK_O = ACK_I && w_g0;
   assign m1_ACK_O = ACK_I && w_g1;

   generate
      if (DAT_ZERO_WHEN_INACTIVE != 0) begin : g_dat_zero
         assign m0_DAT_O = (w_g0 && ACK_I) ? DAT_I : 32'd0;
         assign m1_DAT_O = (w_g1 && ACK_I) ? DAT_I : 32'd0;
      end else begin : g_dat_bcast
         assign m0_DAT_O = RST_I ? DAT_I : 32'd0;
         assign m1_DAT_O = RST_I ? DAT_I : 32'd0;
      end
   endgenerate

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] r_tmo_cnt;
   logic        r_tmo_flag;

   assign w_tmo_hit = w_stb_mux && !ACK_I && (r_tmo_cnt == TMO_LAST);
   assign m0_ERR_O  = w_tmo_hit && w_g0;
   assign m1_ERR_O  = w_tmo_hit && w_g1;
   assign tmo_flag  = r_tmo_flag;

   // Watchdog: count stalled strobe cycles, restart on ACK, on grant change and after firing.
   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         r_tmo_cnt  <= '0;
         r_tmo_flag <= 1'b0;
      end else begin
         if (r_state == ST_IDLE || w_state_next != r_state || ACK_I || w_tmo_hit) begin
            r_tmo_cnt <= '0;
         end else if (w_stb_mux) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
         end
         if (w_tmo_hit) begin
            r_tmo_flag <= 1'b1;
         end
      end
   end
`else
   logic w_unused_tmo;
   assign w_tmo_hit    = 1'b0;
   assign w_unused_tmo = ^TMO_LAST;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed testbench for wb_arbiter2. Two instances share all inputs:
// u_fp uses fixed priority, u_rr uses round-robin. Timeout checks are
// compiled in only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;
   logic [31:0] dat_i;
   logic        ack_i;

   logic [31:0] a_m0_dat_o, a_m1_dat_o, a_adr_o, a_dat_o;
   logic        a_m0_ack_o, a_m1_ack_o, a_cyc_o, a_stb_o, a_we_o;
   logic [3:0]  a_sel_o;
   logic [1:0]  a_gnt;
   logic [31:0] b_m0_dat_o, b_m1_dat_o, b_adr_o, b_dat_o;
   logic        b_m0_ack_o, b_m1_ack_o, b_cyc_o, b_stb_o, b_we_o;
   logic [3:0]  b_sel_o;
   logic [1:0]  b_gnt;
`ifdef WB_ARB_TIMEOUT_EN
   logic        a_m0_err, a_m1_err, a_tmo, b_m0_err, b_m1_err, b_tmo;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_arbiter2 #(.ADRWIDTH(32), .PRIORITY_MODE(0), .DAT_ZERO_WHEN_INACTIVE(1), .TIMEOUT_CYCLES(4)) u_fp (
      .CLK_I(clk), .RST_I(rst_n),
      .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we), .m0_SEL_I(m0_sel),
      .m0_ADR_I(m0_adr), .m0_DAT_I(m0_dat), .m0_DAT_O(a_m0_dat_o), .m0_ACK_O(a_m0_ack_o),
      .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we), .m1_SEL_I(m1_sel),
      .m1_ADR_I(m1_adr), .m1_DAT_I(m1_dat), .m1_DAT_O(a_m1_dat_o), .m1_ACK_O(a_m1_ack_o),
      .CYC_O(a_cyc_o), .STB_O(a_stb_o), .WE_O(a_we_o), .SEL_O(a_sel_o), .ADR_O(a_adr_o),
      .DAT_O(a_dat_o), .DAT_I(dat_i), .ACK_I(ack_i), .gnt(a_gnt)
`ifdef WB_ARB_TIMEOUT_EN
      , .m0_ERR_O(a_m0_err), .m1_ERR_O(a_m1_err), .tmo_flag(a_tmo)
`endif
   );

   wb_arbiter2 #(.ADRWIDTH(32), .PRIORITY_MODE(1), .DAT_ZERO_WHEN_INACTIVE(1), .TIMEOUT_CYCLES(4)) u_rr (
      .CLK_I(clk), .RST_I(rst_n),
      .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we), .m0_SEL_I(m0_sel),
      .m0_ADR_I(m0_adr), .m0_DAT_I(m0_dat), .m0_DAT_O(b_m0_dat_o), .m0_ACK_O(b_m0_ack_o),
      .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we), .m1_SEL_I(m1_sel),
      .m1_ADR_I(m1_adr), .m1_DAT_I(m1_dat), .m1_DAT_O(b_m1_dat_o), .m1_ACK_O(b_m1_ack_o),
      .CYC_O(b_cyc_o), .STB_O(b_stb_o), .WE_O(b_we_o), .SEL_O(b_sel_o), .ADR_O(b_adr_o),
      .DAT_O(b_dat_o), .DAT_I(dat_i), .ACK_I(ack_i), .gnt(b_gnt)
`ifdef WB_ARB_TIMEOUT_EN
      , .m0_ERR_O(b_m0_err), .m1_ERR_O(b_m1_err), .tmo_flag(b_tmo)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_gnt_fp", a_gnt, 2'b00);
         chk("rst_gnt_rr", b_gnt, 2'b00);
         chk("rst_cyc", a_cyc_o, 1'b0);
         chk("rst_acks", {a_m0_ack_o, a_m1_ack_o}, 2'b00);
      end
      rst_n = 1'b1;
      $display("reset: 3 cycles low, released");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0; ack_i = 1'b0; dat_i = '0;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_dat = '0;

      // --- Reset, then idle with no requests ---
      reset_dut();
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("idle_gnt", a_gnt, 2'b00);
         chk("idle_cyc", a_cyc_o, 1'b0);
         chk("idle_acks", {a_m0_ack_o, a_m1_ack_o, b_m0_ack_o, b_m1_ack_o}, 4'b0000);
         tick();
      end
      $display("idle: no requests, bus quiet");

      // --- m0 single read of 0x100, ACK two cycles after STB_O ---
      m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h0000_0100;
      #1;
      chk("rd_req_gnt", a_gnt, 2'b00);
      chk("rd_req_stb", a_stb_o, 1'b0);
      tick();
      chk("rd_gnt", a_gnt, 2'b01);
      chk("rd_stb", a_stb_o, 1'b1);
      chk("rd_adr", a_adr_o, 32'h0000_0100);
      chk("rd_we", a_we_o, 1'b0);
      tick();
      dat_i = 32'hDEAD_BEEF; ack_i = 0;
      #1;
      chk("rd_wait_ack", a_m0_ack_o, 1'b0);
      chk("rd_wait_dat", a_m0_dat_o, 32'h0);
      tick();
      ack_i = 1; m0_cyc = 0; m0_stb = 0;
      #1;
      chk("rd_ack", a_m0_ack_o, 1'b1);
      chk("rd_dat", a_m0_dat_o, 32'hDEAD_BEEF);
      chk("rd_m1_dat", a_m1_dat_o, 32'h0);
      chk("rd_m1_ack", a_m1_ack_o, 1'b0);
      tick();
      ack_i = 0;
      #1;
      chk("rd_end_gnt", a_gnt, 2'b00);
      chk("rd_end_dat", a_m0_dat_o, 32'h0);
      chk("rd_end_cyc", a_cyc_o, 1'b0);
      ack_i = 1;
      #1;
      chk("idle_ack_ignored", {a_m0_ack_o, a_m1_ack_o, b_m0_ack_o}, 3'b000);
      chk("idle_ack_dat", a_m0_dat_o, 32'h0);
      tick();
      ack_i = 0;
      $display("m0 read 0x100 -> 0xdeadbeef");

      // --- Both masters, 1-cycle bursts: back-to-back handovers ---
      reset_dut();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200;
      #1;
      chk("rr_c0_gnt", b_gnt, 2'b00);
      tick();
      ack_i = 1; m0_cyc = 0;
      #1;
      chk("rr_c1_gnt", b_gnt, 2'b01);
      chk("rr_c1_ack", {b_m0_ack_o, b_m1_ack_o}, 2'b10);
      tick();
      m0_cyc = 1; m1_cyc = 0;
      #1;
      chk("rr_c2_gnt", b_gnt, 2'b10);
      chk("rr_c2_ack", {b_m0_ack_o, b_m1_ack_o}, 2'b01);
      chk("fp_c2_gnt", a_gnt, 2'b10);
      tick();
      m0_cyc = 0; m1_cyc = 1;
      #1;
      chk("rr_c3_gnt", b_gnt, 2'b01);
      tick();
      m0_cyc = 0; m1_cyc = 0;
      #1;
      chk("rr_c4_gnt", b_gnt, 2'b10);
      tick();
      ack_i = 0; m0_cyc = 1;
      #1;
      chk("both_drop_idle", b_gnt, 2'b00);
      chk("both_drop_idle_fp", a_gnt, 2'b00);
      tick();
      m0_cyc = 0;
      #1;
      chk("solo_m0_rr", b_gnt, 2'b01);
      tick();
      m0_cyc = 1; m1_cyc = 1;
      #1;
      chk("tie_idle", b_gnt, 2'b00);
      tick();
      ack_i = 1;
      #1;
      chk("tie_fp_gnt", a_gnt, 2'b01);
      chk("tie_rr_gnt", b_gnt, 2'b10);
      chk("tie_fp_ack", {a_m0_ack_o, a_m1_ack_o}, 2'b10);
      chk("tie_rr_ack", {b_m0_ack_o, b_m1_ack_o}, 2'b01);
      m0_cyc = 0; m1_cyc = 0; m0_stb = 0; m1_stb = 0; ack_i = 0;
      tick();
      $display("handover sequence 01,10,01,10 and tie-break checked");

      // --- Fixed priority: m1 4-beat write burst while m0 waits ---
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3; m1_adr = 32'h0000_0200; m1_dat = 32'h1111_0000;
      #1;
      chk("burst_idle", a_gnt, 2'b00);
      tick();
      for (int i = 0; i < 4; i++) begin
         m0_cyc = 1; m0_stb = 1;
         m1_adr = 32'h0000_0200 + 32'(i * 4);
         m1_dat = 32'h0000_00A0 + 32'(i);
         dat_i  = 32'hC0DE_0000 + 32'(i);
         ack_i  = 1;
         if (i == 3) begin
            m1_cyc = 0; m1_stb = 0;
         end
         #1;
         chk("burst_gnt", a_gnt, 2'b10);
         chk("burst_m1_ack", a_m1_ack_o, 1'b1);
         chk("burst_m0_ack", a_m0_ack_o, 1'b0);
         chk("burst_adr", a_adr_o, 32'h0000_0200 + 32'(i * 4));
         chk("burst_wdat", a_dat_o, 32'h0000_00A0 + 32'(i));
         chk("burst_rdat", a_m1_dat_o, 32'hC0DE_0000 + 32'(i));
         chk("burst_m0_dat", a_m0_dat_o, 32'h0);
         chk("burst_sel", a_sel_o, 4'h3);
         $display("burst beat %0d adr=0x%08h", i, a_adr_o);
         tick();
      end
      ack_i = 0;
      #1;
      chk("burst_handover_fp", a_gnt, 2'b01);
      chk("burst_handover_rr", b_gnt, 2'b01);
      m0_cyc = 0; m0_stb = 0;
      tick();

      // --- Reset during G1 with STB and ACK in the same cycle ---
      m1_cyc = 1; m1_stb = 1; m1_we = 0;
      tick();
      #1;
      chk("pre_rst_gnt", a_gnt, 2'b10);
      chk("pre_rst_stb", a_stb_o, 1'b1);
      rst_n = 0; ack_i = 1;
      #1;
      chk("rst_cycle_ack", a_m1_ack_o, 1'b0);
      tick();
      rst_n = 1;
      #1;
      chk("post_rst_gnt", a_gnt, 2'b00);
      chk("post_rst_ack", a_m1_ack_o, 1'b0);
      chk("post_rst_cyc", a_cyc_o, 1'b0);
      chk("post_rst_rr", {b_gnt, b_m1_ack_o, b_cyc_o}, 4'b0000);
      m1_cyc = 0; m1_stb = 0; ack_i = 0;
      tick();
      $display("reset mid-transfer aborted grant");

`ifdef WB_ARB_TIMEOUT_EN
      // --- Watchdog: slave never ACKs an m0 write ---
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h0000_0300;
      #1;
      chk("tmo_flag_clear", a_tmo, 1'b0);
      tick();
      for (int s = 1; s <= 4; s++) begin
         chk("tmo_err", a_m0_err, (s == 4) ? 1'b1 : 1'b0);
         chk("tmo_stb", a_stb_o, (s == 4) ? 1'b0 : 1'b1);
         chk("tmo_m1_err", a_m1_err, 1'b0);
         chk("tmo_gnt", a_gnt, 2'b01);
         tick();
      end
      chk("tmo_err_pulse", a_m0_err, 1'b0);
      chk("tmo_flag_set", a_tmo, 1'b1);
      chk("tmo_stb_again", a_stb_o, 1'b1);
      chk("tmo_gnt_kept", a_gnt, 2'b01);
      tick();
      chk("tmo_flag_sticky", a_tmo, 1'b1);
      m0_cyc = 0; m0_stb = 0;
      tick();
      chk("tmo_idle_gnt", a_gnt, 2'b00);
      chk("tmo_flag_idle", a_tmo, 1'b1);
      reset_dut();
      #1;
      chk("tmo_flag_rst", a_tmo, 1'b0);
      $display("watchdog fired on stalled m0 write");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
